// File: rtl/multiplier.sv
// Parallel bank of KERNEL_SIZE^2 signed Q(W/2).(W/2) multipliers.
// Stage 1 holds full 2W-bit products; stage 2 holds the truncated, wrapping W-bit slice.
module multiplier #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 5
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          i_valid,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] pixel_data,
  output logic                                          o_valid,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] result
);

  localparam int N  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int W  = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;

  logic valid1_d, valid1_q;
  logic valid2_d, valid2_q;

  // Stage valid bits follow the window through the pipeline
  always_comb begin
    valid1_d = i_valid;
    valid2_d = valid1_q;
  end

  // Stage valid registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
    end else begin
      valid1_q <= valid1_d;
      valid2_q <= valid2_d;
    end
  end

  assign o_valid = valid2_q;

  for (genvar j = 0; j < N; j++) begin : g_lane
    logic signed [PW-1:0] prod_d, prod_q;
    logic        [W-1:0]  res_d, res_q;
    logic                 unused_bits_s;

    // Full-precision product, held when no window is offered
    always_comb begin
      if (i_valid) begin
        prod_d = PW'($signed(weights[j*W +: W])) * PW'($signed(pixel_data[j*W +: W]));
      end else begin
        prod_d = prod_q;
      end
    end

    // Sign bit plus W-1 magnitude bits: fraction dropped (floor), high bits wrap
    always_comb begin
      if (valid1_q) begin
        res_d = {prod_q[PW-1], prod_q[3*W/2-2 : W/2]};
      end else begin
        res_d = res_q;
      end
    end

    // Lane pipeline registers
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        prod_q <= '0;
        res_q  <= '0;
      end else begin
        prod_q <= prod_d;
        res_q  <= res_d;
      end
    end

    assign result[j*W +: W] = res_q;
    assign unused_bits_s    = ^{prod_q[W/2-1:0], prod_q[PW-2 : 3*W/2-1]};
  end

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: directed vectors plus random windows
// compared against an arithmetic reference of floor(p/2^(W/2)) with wrap.
module tb_multiplier;

  localparam int W = 16;
  localparam int K = 5;
  localparam int N = K * K;
  typedef logic [N*W-1:0] vec_t;

  logic clk = 1'b0;
  logic reset;
  logic i_valid;
  vec_t weights;
  vec_t pixel_data;
  logic o_valid;
  vec_t result;

  int n_checks = 0;
  int n_fail   = 0;

  logic sv  [64];
  vec_t sw  [64];
  vec_t sp  [64];
  logic ov  [64];
  vec_t orr [64];
  vec_t model_res;

  multiplier #(.DATA_WIDTH(W), .KERNEL_SIZE(K)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .weights(weights),
    .pixel_data(pixel_data), .o_valid(o_valid), .result(result)
  );

  always #5 clk = ~clk;

  function automatic vec_t ref_window(input vec_t w, input vec_t p);
    vec_t        r;
    longint      a, b, prod;
    logic [14:0] mag;
    for (int j = 0; j < N; j++) begin
      a    = longint'($signed(w[j*W +: W]));
      b    = longint'($signed(p[j*W +: W]));
      prod = a * b;
      mag  = 15'((prod >>> 8) & 64'sh7FFF);
      r[j*W +: W] = {(prod < 0), mag};
    end
    return r;
  endfunction

  function automatic vec_t splat(input logic [W-1:0] v);
    vec_t r;
    for (int j = 0; j < N; j++) r[j*W +: W] = v;
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t r;
    for (int j = 0; j < N; j++) r[j*W +: W] = 16'($urandom());
    return r;
  endfunction

  task automatic clear_stim();
    for (int c = 0; c < 64; c++) begin
      sv[c] = 1'b0;
      sw[c] = rand_vec();
      sp[c] = rand_vec();
    end
  endtask

  // Each iteration: capture outputs at the falling edge, then drive that cycle's inputs
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      ov[c]      = o_valid;
      orr[c]     = result;
      i_valid    = sv[c];
      weights    = sw[c];
      pixel_data = sp[c];
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; i_valid = 1'b0; weights = '0; pixel_data = '0;
    #1 reset = 1'b1;
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", o_valid); end
    n_checks++; if (result !== '0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
    i_valid = 1'b1; weights = rand_vec(); pixel_data = rand_vec();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hold_valid got %b want 0", o_valid); end
    @(negedge clk);
    reset = 1'b0; i_valid = 1'b0;
    model_res = '0;
    clear_stim();
    run(4);
    for (int c = 0; c < 4; c++) begin
      n_checks++; if (ov[c] !== 1'b0) begin n_fail++; $display("FAIL reset_ignore_valid c=%0d got %b want 0", c, ov[c]); end
      n_checks++; if (orr[c] !== '0) begin n_fail++; $display("FAIL reset_ignore_result c=%0d got %h want 0", c, orr[c]); end
    end
  endtask

  task automatic test_identity();
    clear_stim();
    sv[0] = 1'b1; sw[0] = splat(16'h0100); sp[0] = splat(16'h0100);
    run(5);
    n_checks++; if (ov[1] !== 1'b0) begin n_fail++; $display("FAIL identity_early got %b want 0", ov[1]); end
    n_checks++; if (ov[2] !== 1'b1) begin n_fail++; $display("FAIL identity_valid got %b want 1", ov[2]); end
    n_checks++; if (ov[3] !== 1'b0) begin n_fail++; $display("FAIL identity_pulse got %b want 0", ov[3]); end
    n_checks++; if (orr[2] !== splat(16'h0100)) begin n_fail++; $display("FAIL identity_result got %h want all 0100", orr[2]); end
    model_res = splat(16'h0100);
  endtask

  task automatic test_lanes();
    vec_t w, p, e;
    w = splat(16'h0080); p = splat(16'h0200); e = splat(16'h0100);
    w[0 +: W]    = 16'h0200; p[0 +: W]    = 16'h0300; e[0 +: W]    = 16'h0600;
    w[W +: W]    = 16'hFF00; p[W +: W]    = 16'h0100; e[W +: W]    = 16'hFF00;
    w[2*W +: W]  = 16'hFF00; p[2*W +: W]  = 16'hFF00; e[2*W +: W]  = 16'h0100;
    w[24*W +: W] = 16'h0000; p[24*W +: W] = 16'h7FFF; e[24*W +: W] = 16'h0000;
    clear_stim();
    sv[0] = 1'b1; sw[0] = w; sp[0] = p;
    run(4);
    n_checks++; if (ov[2] !== 1'b1) begin n_fail++; $display("FAIL lanes_valid got %b want 1", ov[2]); end
    for (int j = 0; j < N; j++) begin
      n_checks++;
      if (orr[2][j*W +: W] !== e[j*W +: W]) begin
        n_fail++; $display("FAIL lanes_result lane=%0d got %h want %h", j, orr[2][j*W +: W], e[j*W +: W]);
      end
    end
    model_res = e;
  endtask

  task automatic test_trunc();
    logic [W-1:0] ta [3];
    logic [W-1:0] tb [3];
    logic [W-1:0] te [3];
    ta[0] = 16'h0001; tb[0] = 16'h0001; te[0] = 16'h0000;
    ta[1] = 16'h7F00; tb[1] = 16'h0200; te[1] = 16'h7E00;
    ta[2] = 16'h0180; tb[2] = 16'h0180; te[2] = 16'h0240;
    clear_stim();
    for (int k = 0; k < 3; k++) begin
      sv[k] = 1'b1; sw[k] = splat(ta[k]); sp[k] = splat(tb[k]);
    end
    run(6);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (ov[k+2] !== 1'b1) begin n_fail++; $display("FAIL trunc_valid k=%0d got %b want 1", k, ov[k+2]); end
      n_checks++;
      if (orr[k+2] !== splat(te[k])) begin
        n_fail++; $display("FAIL trunc_result k=%0d got %h want all %h", k, orr[k+2][W-1:0], te[k]);
      end
    end
    model_res = splat(te[2]);
  endtask

  task automatic test_stream();
    int   nvalid;
    logic ev;
    clear_stim();
    for (int k = 0; k < 10; k++) sv[k] = 1'b1;
    run(13);
    nvalid = 0;
    for (int c = 0; c < 13; c++) begin
      ev = (c >= 2) ? sv[c-2] : 1'b0;
      if (ev) model_res = ref_window(sw[c-2], sp[c-2]);
      if (ov[c] === 1'b1) nvalid++;
      n_checks++; if (ov[c] !== ev) begin n_fail++; $display("FAIL stream_valid c=%0d got %b want %b", c, ov[c], ev); end
      n_checks++; if (orr[c] !== model_res) begin n_fail++; $display("FAIL stream_result c=%0d got %h want %h", c, orr[c], model_res); end
    end
    n_checks++; if (nvalid != 10) begin n_fail++; $display("FAIL stream_count got %0d want 10", nvalid); end
  endtask

  task automatic test_bubble();
    logic ev;
    vec_t first;
    clear_stim();
    sv[0] = 1'b1; sv[1] = 1'b0; sv[2] = 1'b1;
    first = ref_window(sw[0], sp[0]);
    run(6);
    for (int c = 0; c < 6; c++) begin
      ev = (c >= 2) ? sv[c-2] : 1'b0;
      if (ev) model_res = ref_window(sw[c-2], sp[c-2]);
      n_checks++; if (ov[c] !== ev) begin n_fail++; $display("FAIL bubble_valid c=%0d got %b want %b", c, ov[c], ev); end
      n_checks++; if (orr[c] !== model_res) begin n_fail++; $display("FAIL bubble_result c=%0d got %h want %h", c, orr[c], model_res); end
    end
    n_checks++; if (orr[3] !== first) begin n_fail++; $display("FAIL bubble_hold got %h want %h", orr[3], first); end
  endtask

  task automatic test_reset_midflight();
    vec_t wa, pa, wb, pb, wc, pc, ref_a, ref_c;
    logic ev;
    vec_t er;
    wa = rand_vec(); pa = rand_vec(); wb = rand_vec(); pb = rand_vec();
    wc = rand_vec(); pc = rand_vec();
    ref_a = ref_window(wa, pa);
    ref_c = ref_window(wc, pc);
    @(negedge clk); i_valid = 1'b1; weights = wa; pixel_data = pa;
    @(negedge clk); i_valid = 1'b1; weights = wb; pixel_data = pb;
    @(negedge clk); i_valid = 1'b0;
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL midflight_pre_valid got %b want 1", o_valid); end
    n_checks++; if (result !== ref_a) begin n_fail++; $display("FAIL midflight_pre_result got %h want %h", result, ref_a); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL midflight_async_valid got %b want 0", o_valid); end
    n_checks++; if (result !== '0) begin n_fail++; $display("FAIL midflight_async_result got %h want 0", result); end
    i_valid = 1'b1; weights = rand_vec(); pixel_data = rand_vec();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; i_valid = 1'b1; weights = wc; pixel_data = pc;
    clear_stim();
    run(5);
    for (int c = 0; c < 5; c++) begin
      ev = (c == 1);
      er = (c >= 1) ? ref_c : '0;
      n_checks++; if (ov[c] !== ev) begin n_fail++; $display("FAIL midflight_valid c=%0d got %b want %b", c, ov[c], ev); end
      n_checks++; if (orr[c] !== er) begin n_fail++; $display("FAIL midflight_result c=%0d got %h want %h", c, orr[c], er); end
    end
    model_res = ref_c;
  endtask

  initial begin
    test_reset();
    test_identity();
    test_lanes();
    test_trunc();
    test_stream();
    test_bubble();
    test_reset_midflight();
    test_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
